pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Valid/ready flow controller that sequences a chain of STAGES datapath register stages (plain enable-loaded registers, no internal handshake).
- Generates per-stage load enables and valid bits.
- Collapses bubbles: only occupied stages stall.
- Provides flush, drain and occupancy status so the upstream scheduler can quiesce the pipe.

Parameters:
- STAGES, 4, number of controlled register stages (≥1); stage 0 is input-side, stage STAGES-1 drives the output.
- CNT_W, $clog2(STAGES+1), width of occupancy counter.

Ports:
- clk  input  1  clock; one clock.
- rst  input  1  reset, asynchronous and active-low (asserted at 0).
- in_valid  input  1  upstream has data for stage 0.
- in_ready  output  1  controller accepts upstream data this cycle.
- out_valid  output  1  stage STAGES-1 holds valid data.
- out_ready  input  1  downstream accepts output data.
- flush  input  1  synchronous discard of all in-flight data.
- drain_req  input  1  level; block new input until pipe empties.
- drained  output  1  drain_req high and pipe empty.
- stage_en  output  STAGES  per-stage register load enable.
- stage_valid  output  STAGES  per-stage valid bits v[i].
- occupancy  output  CNT_W  count of valid stages.
- busy  output  1  occupancy != 0.

Behaviour:
- Reset (rst=0, async): v=0, occupancy=0. Combinationally this gives out_valid=0, busy=0, stage_en=0. in_ready follows the normal equation after reset.
- Ready chain (combinational):
  - r[STAGES-1] = ~v[STAGES-1] | out_ready.
  - r[i] = ~v[i] | r[i+1].
- Upstream valid: u[0] = in_valid & in_ready; u[i] = v[i-1] for i>0.
- Stage enable: stage_en[i] = r[i] & u[i] & ~flush. Bubbles never load the datapath.
- Next-state, when flush=0: v[i] <= r[i] ? u[i] : v[i]. Stage i is cleared when it hands off with nothing arriving; it holds when stalled.
- in_ready = r[0] & ~drain_req & ~flush.
- out_valid = v[STAGES-1] & ~flush.
- Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Occupancy:
  - Registered counter: +1 on in_fire, -1 on out_fire; no change if both or neither.
  - Must always equal popcount(v) (bench assertion).
  - Never exceeds STAGES and never underflows.
- busy = (occupancy != 0).
- drained = drain_req & (occupancy == 0). Combinational; held as long as both conditions hold.
- Latency:
  - in_fire at cycle T gives out_valid at T+STAGES when unstalled.
  - Full-rate throughput: one transfer per cycle with out_ready held 1.
- Full pipe with out_ready=1: in_ready=1 the same cycle. Simultaneous in and out fire; occupancy stays at STAGES.
- Full pipe with out_ready=0: all stage_en=0, in_ready=0, state held.
- Partial stall: a bubble at stage k lets stages <k advance while stages >k hold.
- Flush:
  - In the flush cycle, all stage_en=0, in_ready=0, out_valid=0, so no transfer occurs.
  - Next edge: v=0, occupancy=0.
  - flush has priority over drain_req and handshakes.
- drain_req with flush: flush empties the pipe; drained asserts the following cycle.
- Reset asserted mid-operation clears all state immediately, regardless of clock.
- STAGES=1: r[0] = ~v[0] | out_ready; all rules still apply.

Test Plan:
- Reset then idle (in_valid=0, out_ready=1, 10 cycles) -> v=0000, occupancy=0, busy=0, in_ready=1, stage_en=0000.
- Stream 8 tokens back-to-back, out_ready=1, STAGES=4 -> first out_valid 4 cycles after first in_fire; 8 consecutive out_fires; occupancy peaks at 4; stage_en=1111 in steady state.
- Fill 4 tokens with out_ready=0 -> in_ready=0 after 4th in_fire; occupancy=4; stage_en=0000 while stalled. Then out_ready=1 with in_valid=1 -> in_ready=1 the same cycle, occupancy stays 4.
- Single token, then out_ready=0 for 3 cycles while 2 more arrive -> tokens collapse into v=1110 (stage3 held; a bubble never sits between tokens); occupancy=3.
- Flush with v=1011 and in_valid=1 -> in_ready=0, out_valid=0, stage_en=0000 that cycle; next cycle v=0000, occupancy=0.
- drain_req=1 with occupancy=3, in_valid=1, out_ready=1 -> in_ready=0 throughout; drained asserts exactly when the 3rd out_fire completes (occupancy=0). Async rst=0 mid-drain -> immediate v=0 without a clock edge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Valid/ready sequencer for a chain of enable-loaded datapath register stages.
// Bubbles are squeezed out: a stage only stalls when it and every stage ahead are occupied.
module pipeline_ctrl #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              drain_req,
    output logic              drained,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]  occupancy,
    output logic              busy
);

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] upv;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_fire, out_fire;

    // A stage can accept when it is empty or its current content moves on this cycle.
    always_comb begin
        rdy = '0;
        rdy[STAGES-1] = ~v_q[STAGES-1] | out_ready;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            rdy[i] = ~v_q[i] | rdy[i+1];
        end
    end

    assign in_ready  = rdy[0] & ~drain_req & ~flush;
    assign out_valid = v_q[STAGES-1] & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        upv    = '0;
        upv[0] = in_fire;
        for (int i = 1; i < int'(STAGES); i++) begin
            upv[i] = v_q[i-1];
        end
    end

    assign stage_en = rdy & upv & {STAGES{~flush}};

    always_comb begin
        v_d = v_q;
        if (flush) begin
            v_d = '0;
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                if (rdy[i]) begin
                    v_d[i] = upv[i];
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (in_fire && !out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (out_fire && !in_fire) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
        end
    end

    assign stage_valid = v_q;
    assign occupancy   = cnt_q;
    assign busy        = (cnt_q != '0);
    assign drained     = drain_req & (cnt_q == '0);

endmodule
